// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer: carries pc, T_new and an opaque payload.
// Latency 1 cycle; up_ready = !skid.valid (registered), so a downstream stall never reaches upstream combinationally.
module pipe_skid_reg #(
  parameter int          PAYLOAD_W = 128,
  parameter int          TNEW_W    = 2,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Req,
  input  logic                 flush,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [31:0]          up_pc,
  input  logic [TNEW_W-1:0]    up_tnew,
  input  logic [PAYLOAD_W-1:0] up_payload,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [31:0]          dn_pc,
  output logic [TNEW_W-1:0]    dn_tnew,
  output logic [PAYLOAD_W-1:0] dn_payload,
  output logic [1:0]           occupancy
);

  logic                 m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic [31:0]          m_pc_q, m_pc_d, s_pc_q, s_pc_d;
  logic [TNEW_W-1:0]    m_tnew_q, m_tnew_d, s_tnew_q, s_tnew_d;
  logic [PAYLOAD_W-1:0] m_pay_q, m_pay_d, s_pay_q, s_pay_d;
  logic                 accept, consume;

  function automatic logic [TNEW_W-1:0] dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  assign up_ready  = reset & ~s_vld_q;
  assign accept    = up_valid & up_ready;
  assign consume   = m_vld_q & dn_ready;
  assign dn_valid  = m_vld_q;
  assign dn_pc     = m_pc_q;
  assign dn_tnew   = m_tnew_q;
  assign dn_payload = m_pay_q;
  assign occupancy = {1'b0, m_vld_q} + {1'b0, s_vld_q};

  always_comb begin
    m_vld_d  = m_vld_q;
    m_pc_d   = m_pc_q;
    m_tnew_d = m_tnew_q;
    m_pay_d  = m_pay_q;
    s_vld_d  = s_vld_q;
    s_pc_d   = s_pc_q;
    s_tnew_d = s_tnew_q;
    s_pay_d  = s_pay_q;
    if (Req || flush) begin
      // Upstream entry is dropped; upstream is being flushed in the same cycle.
      m_vld_d  = 1'b0;
      m_tnew_d = '0;
      m_pay_d  = '0;
      s_vld_d  = 1'b0;
      s_pc_d   = '0;
      s_tnew_d = '0;
      s_pay_d  = '0;
      if (Req) m_pc_d = EXC_PC;
    end else if (!m_vld_q || consume) begin
      if (s_vld_q) begin
        m_vld_d  = 1'b1;
        m_pc_d   = s_pc_q;
        m_tnew_d = dec(s_tnew_q);
        m_pay_d  = s_pay_q;
        s_vld_d  = 1'b0;
        s_pc_d   = '0;
        s_tnew_d = '0;
        s_pay_d  = '0;
      end else if (accept) begin
        m_vld_d  = 1'b1;
        m_pc_d   = up_pc;
        m_tnew_d = dec(up_tnew);
        m_pay_d  = up_payload;
      end else begin
        // Bubble keeps the last pc visible on dn_pc.
        m_vld_d  = 1'b0;
        m_tnew_d = '0;
        m_pay_d  = '0;
      end
    end else begin
      m_tnew_d = dec(m_tnew_q);
      if (accept) begin
        s_vld_d  = 1'b1;
        s_pc_d   = up_pc;
        s_tnew_d = dec(up_tnew);
        s_pay_d  = up_payload;
      end else if (s_vld_q) begin
        s_tnew_d = dec(s_tnew_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_vld_q  <= 1'b0;
      m_pc_q   <= PC_RESET;
      m_tnew_q <= '0;
      m_pay_q  <= '0;
      s_vld_q  <= 1'b0;
      s_pc_q   <= '0;
      s_tnew_q <= '0;
      s_pay_q  <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_pc_q   <= m_pc_d;
      m_tnew_q <= m_tnew_d;
      m_pay_q  <= m_pay_d;
      s_vld_q  <= s_vld_d;
      s_pc_q   <= s_pc_d;
      s_tnew_q <= s_tnew_d;
      s_pay_q  <= s_pay_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed plan steps plus random traffic against an in-order queue model.
module tb_pipe_skid_reg;
  localparam int          PW   = 128;
  localparam logic [31:0] PCR  = 32'h0000_0000;
  localparam logic [31:0] EXCP = 32'h0000_4180;

  logic          clk = 1'b0;
  logic          reset, Req, flush, up_valid, up_ready, dn_valid, dn_ready;
  logic [31:0]   up_pc, dn_pc;
  logic [1:0]    up_tnew, dn_tnew, occupancy;
  logic [PW-1:0] up_payload, dn_payload;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0]   pc;
    logic [1:0]    tnew;
    logic [PW-1:0] pay;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mdl_pc = PCR;

  pipe_skid_reg #(.PAYLOAD_W(PW), .TNEW_W(2), .PC_RESET(PCR), .EXC_PC(EXCP)) dut (
    .clk(clk), .reset(reset), .Req(Req), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc), .up_tnew(up_tnew),
    .up_payload(up_payload), .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_pc(dn_pc),
    .dn_tnew(dn_tnew), .dn_payload(dn_payload), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] dec2(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the current state.
  task automatic check_model();
    chk("dn_valid", PW'(dn_valid), PW'(q.size() > 0));
    chk("dn_pc", PW'(dn_pc), PW'(mdl_pc));
    chk("dn_tnew", PW'(dn_tnew), PW'((q.size() > 0) ? q[0].tnew : 2'd0));
    chk("dn_payload", dn_payload, (q.size() > 0) ? q[0].pay : '0);
    chk("occupancy", PW'(occupancy), PW'(q.size()));
    chk("up_ready", PW'(up_ready), PW'(reset && q.size() < 2));
  endtask

  task automatic model_edge();
    bit acc, con;
    ent_t e;
    if (!reset) begin
      q.delete();
      mdl_pc = PCR;
    end else begin
      acc = up_valid && (q.size() < 2);
      con = dn_ready && (q.size() > 0);
      if (Req || flush) begin
        q.delete();
        if (Req) mdl_pc = EXCP;
      end else begin
        foreach (q[i]) q[i].tnew = dec2(q[i].tnew);
        if (con) void'(q.pop_front());
        if (acc) begin
          e.pc = up_pc; e.tnew = dec2(up_tnew); e.pay = up_payload;
          q.push_back(e);
        end
        if (q.size() > 0) mdl_pc = q[0].pc;
      end
    end
  endtask

  // Inputs are already driven; check at negedge, advance model at posedge, return 1 time unit later.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] tn, input logic rdy);
    up_valid = v; up_pc = pc; up_tnew = tn; dn_ready = rdy;
    up_payload = {$urandom, $urandom, $urandom, $urandom};
    Req = 1'b0; flush = 1'b0;
  endtask

  task automatic randomize_inputs();
    up_valid = 1'($urandom); dn_ready = 1'($urandom);
    up_pc = $urandom; up_tnew = 2'($urandom);
    up_payload = {$urandom, $urandom, $urandom, $urandom};
    Req = ($urandom_range(0, 39) == 0);
    flush = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
    end
    chk("rst_dn_pc", PW'(dn_pc), PW'(PCR));
    chk("rst_dn_valid", PW'(dn_valid), PW'(0));
    chk("rst_up_ready", PW'(up_ready), PW'(0));
    chk("rst_occupancy", PW'(occupancy), PW'(0));
    reset = 1'b1;
    #1 chk("up_ready_after_release", PW'(up_ready), PW'(1));

    // Streaming at full rate
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 2'd2, 1'b1);
      tick();
      chk("stream_pc", PW'(dn_pc), PW'(32'h3000 + 32'(4 * i)));
      chk("stream_tnew", PW'(dn_tnew), PW'(1));
      chk("stream_occ", PW'(occupancy), PW'(1));
    end
    drive(1'b0, 32'h0, 2'd0, 1'b1);
    tick();
    chk("bubble_pc_kept", PW'(dn_pc), PW'(32'h3008));

    // Stall and skid
    drive(1'b1, 32'h3000, 2'd3, 1'b1);
    tick();
    chk("skid_m_tnew", PW'(dn_tnew), PW'(2));
    drive(1'b1, 32'h3004, 2'd3, 1'b0);
    tick();
    chk("skid_occ2", PW'(occupancy), PW'(2));
    chk("skid_up_ready0", PW'(up_ready), PW'(0));
    chk("skid_tnew1", PW'(dn_tnew), PW'(1));
    drive(1'b1, 32'h3abc, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("skid_tnew_floor", PW'(dn_tnew), PW'(0));
    chk("skid_full_ignores_up", PW'(occupancy), PW'(2));
    drive(1'b0, 32'h0, 2'd0, 1'b1);
    tick();
    chk("skid_drain_pc", PW'(dn_pc), PW'(32'h3004));
    chk("skid_drain_occ", PW'(occupancy), PW'(1));

    // Exception with full buffer
    drive(1'b1, 32'h3008, 2'd1, 1'b0);
    tick();
    chk("exc_pre_occ", PW'(occupancy), PW'(2));
    drive(1'b1, 32'h300c, 2'd1, 1'b1);
    Req = 1'b1;
    tick();
    chk("exc_pc", PW'(dn_pc), PW'(EXCP));
    chk("exc_valid", PW'(dn_valid), PW'(0));
    chk("exc_payload", dn_payload, '0);
    chk("exc_occ", PW'(occupancy), PW'(0));
    chk("exc_up_ready", PW'(up_ready), PW'(1));

    // Flush keeps pc, flush+Req redirects
    drive(1'b1, 32'h3010, 2'd2, 1'b0);
    tick();
    drive(1'b1, 32'h3014, 2'd2, 1'b0);
    flush = 1'b1;
    tick();
    chk("flush_pc", PW'(dn_pc), PW'(32'h3010));
    chk("flush_valid", PW'(dn_valid), PW'(0));
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    flush = 1'b1; Req = 1'b1;
    tick();
    chk("flush_req_pc", PW'(dn_pc), PW'(EXCP));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      tick();
    end

    // Asynchronous reset mid-cycle with a full buffer
    drive(1'b1, 32'h5000, 2'd3, 1'b0);
    tick();
    drive(1'b1, 32'h5004, 2'd3, 1'b0);
    tick();
    chk("async_pre_occ", PW'(occupancy), PW'(2));
    reset = 1'b0;
    #2;
    q.delete();
    mdl_pc = PCR;
    chk("async_dn_valid", PW'(dn_valid), PW'(0));
    chk("async_dn_pc", PW'(dn_pc), PW'(PCR));
    chk("async_occ", PW'(occupancy), PW'(0));
    chk("async_up_ready", PW'(up_ready), PW'(0));
    chk("async_dn_tnew", PW'(dn_tnew), PW'(0));
    tick();
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      randomize_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
